ccie_mem_responder: RTL and testbench
=====================================

Name: ccie_mem_responder

Overview:
Memory-side responder for the accelerator cache-line request interface. It accepts read and write requests from an accelerator such as the matrix-multiply engines, services them from a local line-wide RAM, and returns read data with echoed mdata and write completions on the dual-lane write-response channel. It is used as the bench/FPGA-local memory model behind any block that drives rd_req_*/wr_req_*, and its almost-full outputs exercise the initiators' backpressure paths.

Parameters:
ADDR_LMT, 20, read line-address width; write address width is ADDR_LMT+4.
MDATA, 14, request tag width, echoed on the read response.
CACHE_WIDTH, 512, line width in bits (16 dwords).
MEM_DEPTH_LOG2, 10, log2 of RAM lines; addresses use the low MEM_DEPTH_LOG2 line bits (wrap modulo depth).
RD_LATENCY, 4, pipeline stages between RAM access and rd_rsp_valid (>=1).
FIFO_DEPTH_LOG2, 3, log2 of read-request FIFO depth.
AFULL_MARGIN, 2, free slots remaining when the almost-full outputs assert (>=2).
WR_PEND_MAX, 16, capacity of the pending write-response counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
rd_req_addr  in  ADDR_LMT  read line address
rd_req_mdata  in  MDATA  read tag
rd_req_en  in  1  read request strobe, one request per cycle
rd_req_almostfull  out  1  read FIFO count >= depth-AFULL_MARGIN
rd_rsp_valid  out  1  read response strobe
rd_rsp_mdata  out  MDATA  echoed tag
rd_rsp_data  out  CACHE_WIDTH  line data
wr_req_addr  in  ADDR_LMT+4  [ADDR_LMT+3:4] line, [3:0] dword lane
wr_req_mdata  in  MDATA  ignored
wr_req_data  in  CACHE_WIDTH  write data
wr_req_en  in  1  write request strobe
wr_req_now  in  1  flush: release pending write responses
wr_req_direct  in  1  1 = full-line write, 0 = dword write
wr_req_almostfull  out  1  pending count >= WR_PEND_MAX-AFULL_MARGIN
wr_rsp_valid  out  1  first write completion this cycle
wr_rsp_rvalid  out  1  second write completion this cycle
rd_throttle  in  1  test hook: when high, the read FIFO is not popped
err_overflow  out  1  sticky: a request was dropped because the FIFO or counter was full

Behaviour:
- Reset: all outputs are 0, the FIFO is empty, the read pipeline is flushed, the pending count is 0, and the flush flag is 0. RAM contents are not cleared. Reset mid-operation discards in-flight reads and pending completions; no rd_rsp_valid, wr_rsp_valid or wr_rsp_rvalid occurs after rst.
- Read accept: when rd_req_en=1, {addr, mdata} is pushed at the clock edge. If the FIFO is full, the request is dropped and err_overflow is set (sticky until rst).
- Read pop: pops when the FIFO is non-empty and rd_throttle=0, one per cycle. The RAM read happens in the pop cycle, followed by RD_LATENCY register stages carrying valid, mdata and data. With the FIFO empty, a request at edge T produces rd_rsp_valid in cycle T+1+RD_LATENCY. Responses are returned in order with the echoed mdata. Simultaneous push and pop keeps the count unchanged.
- rd_req_almostfull and wr_req_almostfull are registered from the post-update counts. AFULL_MARGIN>=2 covers initiators that issue one request after seeing almost-full.
- Write: applied to RAM at the accept edge.
  - direct=1: the whole line is written.
  - direct=0: wr_req_data[31:0] is written into lane addr[3:0]; the other 15 lanes are unchanged.
- Read/write same line, same cycle: the read returns the old data (read-before-write). Writes accepted at earlier edges are visible.
- Write completions:
  - Each accepted write increments pending. A wr_req_now=1 write sets the flush flag.
  - Each cycle, the registered state retires up to two completions. If pending>=2: wr_rsp_valid and wr_rsp_rvalid are both 1, and pending decreases by 2. If pending==1 and flush=1: only wr_rsp_valid is 1, and pending decreases by 1. Otherwise nothing retires.
  - Flush clears when pending reaches 0.
  - pending_next = pending + accepted - retired.
  - A write with pending==WR_PEND_MAX is still written to RAM, but its completion is dropped and err_overflow is set.
- Address wrap: line index = addr mod 2^MEM_DEPTH_LOG2, applied to both reads and writes.

Decomposition:
- Package ccie_if_pkg: CACHE_WIDTH, DWORDS_PER_LINE=16, LANE_BITS=4, default ADDR_LMT/MDATA, and the AFULL_MARGIN default.
- Sub-module ccie_req_fifo: synchronous FIFO with count output, used for the read requests.
- The RAM, the read pipeline and the write-completion logic stay in the top level.

Test Plan:
- Line readback: direct write of line 5 = {16{32'hA5A5_0000+i}}, then read line 5 with mdata 14'h2A. Required: rd_rsp_valid exactly 5 cycles after the request edge (RD_LATENCY=4), with the data and mdata 14'h2A matching.
- Dword merge: dword write addr 24'h52 with data 32'h1234. Required: a read of line 5 returns lane 2 = 32'h1234 and the other lanes unchanged from the previous scenario.
- Backpressure: rd_throttle=1, issue 6 reads. Required: rd_req_almostfull=1 the cycle after the 6th push. After 9 reads, the 9th is dropped and err_overflow=1. Release the throttle: 8 in-order responses, and almostfull deasserts once count<6.
- Completions: one write with now=0 produces no response. A second write produces wr_rsp_valid=wr_rsp_rvalid=1 on the next cycle. Then a single write with now=1 produces wr_rsp_valid=1 and rvalid=0 on the next cycle.
- Hazard and wrap: read and write of line 7 in the same cycle returns the old value. A read of line 1024+7 returns the new value of line 7.
- Reset mid-flight: issue 4 reads, assert rst 2 cycles later. Required: no rd_rsp_valid afterwards, all outputs 0, and RAM line 5 still returns the prior data after reset.

Source files
------------

// File: rtl/ccie_if_pkg.sv
// Shared constants for the accelerator cache-line request interface.
// Line geometry and the default tag/address widths used by initiators and responders.
package ccie_if_pkg;
    localparam int CACHE_WIDTH      = 512;
    localparam int DWORD_WIDTH      = 32;
    localparam int DWORDS_PER_LINE  = 16;
    localparam int LANE_BITS        = 4;
    localparam int DEF_ADDR_LMT     = 20;
    localparam int DEF_MDATA        = 14;
    localparam int DEF_AFULL_MARGIN = 2;
endpackage

// File: rtl/ccie_req_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is ignored
// (the caller detects that from 'full' and reports it).
module ccie_req_fifo #(
    parameter int WIDTH      = 24,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1 << DEPTH_LOG2);

    logic [WIDTH-1:0]      mem [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  push_ok, pop_ok;

    assign full     = (cnt_q == DEPTH);
    assign empty    = (cnt_q == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr_q];
    assign count    = cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push_ok);
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop_ok);
        cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/ccie_mem_responder.sv
// Memory-side responder: queued reads from a line-wide RAM through a fixed-latency
// pipeline, immediate writes, and paired write completions on two response lanes.
module ccie_mem_responder #(
    parameter int ADDR_LMT        = ccie_if_pkg::DEF_ADDR_LMT,
    parameter int MDATA           = ccie_if_pkg::DEF_MDATA,
    parameter int CACHE_WIDTH     = ccie_if_pkg::CACHE_WIDTH,
    parameter int MEM_DEPTH_LOG2  = 10,
    parameter int RD_LATENCY      = 4,
    parameter int FIFO_DEPTH_LOG2 = 3,
    parameter int AFULL_MARGIN    = ccie_if_pkg::DEF_AFULL_MARGIN,
    parameter int WR_PEND_MAX     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_LMT-1:0]    rd_req_addr,
    input  logic [MDATA-1:0]       rd_req_mdata,
    input  logic                   rd_req_en,
    output logic                   rd_req_almostfull,
    output logic                   rd_rsp_valid,
    output logic [MDATA-1:0]       rd_rsp_mdata,
    output logic [CACHE_WIDTH-1:0] rd_rsp_data,
    input  logic [ADDR_LMT+3:0]    wr_req_addr,
    input  logic [MDATA-1:0]       wr_req_mdata,
    input  logic [CACHE_WIDTH-1:0] wr_req_data,
    input  logic                   wr_req_en,
    input  logic                   wr_req_now,
    input  logic                   wr_req_direct,
    output logic                   wr_req_almostfull,
    output logic                   wr_rsp_valid,
    output logic                   wr_rsp_rvalid,
    input  logic                   rd_throttle,
    output logic                   err_overflow
);
    import ccie_if_pkg::*;

    localparam int FIFO_W = MEM_DEPTH_LOG2 + MDATA;
    localparam int CNT_W  = FIFO_DEPTH_LOG2 + 1;
    localparam int PEND_W = $clog2(WR_PEND_MAX + 1);
    localparam logic [CNT_W-1:0]  RD_AFULL_TH = CNT_W'((1 << FIFO_DEPTH_LOG2) - AFULL_MARGIN);
    localparam logic [PEND_W-1:0] WR_AFULL_TH = PEND_W'(WR_PEND_MAX - AFULL_MARGIN);
    localparam logic [PEND_W-1:0] PEND_MAX    = PEND_W'(WR_PEND_MAX);
    localparam logic [PEND_W-1:0] PEND_TWO    = PEND_W'(2);
    localparam logic [PEND_W-1:0] PEND_ONE    = PEND_W'(1);

    // Requests are strobes with no ready: rd_req_en/wr_req_en are taken at the edge
    // they are sampled; the almost-full outputs are the only backpressure.
    logic [FIFO_W-1:0]         fifo_out;
    logic [CNT_W-1:0]          fifo_count;
    logic                      fifo_full, fifo_empty;
    logic                      rd_pop, rd_push_ok, rd_drop;
    logic [MEM_DEPTH_LOG2-1:0] rd_idx, wr_idx;
    logic [MDATA-1:0]          rd_tag;
    logic [LANE_BITS-1:0]      wr_lane;

    assign rd_pop     = !fifo_empty && !rd_throttle;
    assign rd_push_ok = rd_req_en && !fifo_full;
    assign rd_drop    = rd_req_en && fifo_full;

    ccie_req_fifo #(.WIDTH(FIFO_W), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_req_en),
        .push_data ({rd_req_addr[MEM_DEPTH_LOG2-1:0], rd_req_mdata}),
        .pop       (rd_pop),
        .pop_data  (fifo_out),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rd_idx  = fifo_out[FIFO_W-1 -: MEM_DEPTH_LOG2];
    assign rd_tag  = fifo_out[MDATA-1:0];
    assign wr_idx  = wr_req_addr[LANE_BITS +: MEM_DEPTH_LOG2];
    assign wr_lane = wr_req_addr[LANE_BITS-1:0];

    // Synchronous read port sampled before the same-edge write lands (read-before-write).
    logic [CACHE_WIDTH-1:0] mem [1 << MEM_DEPTH_LOG2];
    logic [CACHE_WIDTH-1:0] ram_rd_q;

    always_ff @(posedge clk) begin
        if (rd_pop) ram_rd_q <= mem[rd_idx];
        if (wr_req_en && !rst) begin
            if (wr_req_direct) mem[wr_idx] <= wr_req_data;
            else mem[wr_idx][wr_lane*DWORD_WIDTH +: DWORD_WIDTH] <= wr_req_data[DWORD_WIDTH-1:0];
        end
    end

    logic                   rd0_valid_q, rd0_valid_d;
    logic [MDATA-1:0]       rd0_mdata_q, rd0_mdata_d;
    logic [RD_LATENCY-1:0]  pipe_valid_q, pipe_valid_d;
    logic [MDATA-1:0]       pipe_mdata_q [RD_LATENCY];
    logic [MDATA-1:0]       pipe_mdata_d [RD_LATENCY];
    logic [CACHE_WIDTH-1:0] pipe_data_q [RD_LATENCY];
    logic [CACHE_WIDTH-1:0] pipe_data_d [RD_LATENCY];

    // Data is zeroed on idle slots so the response bus reads 0 whenever valid is low.
    always_comb begin
        rd0_valid_d     = rd_pop;
        rd0_mdata_d     = rd_pop ? rd_tag : '0;
        pipe_valid_d    = '0;
        pipe_valid_d[0] = rd0_valid_q;
        pipe_mdata_d[0] = rd0_mdata_q;
        pipe_data_d[0]  = rd0_valid_q ? ram_rd_q : '0;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_mdata_d[i] = pipe_mdata_q[i-1];
            pipe_data_d[i]  = pipe_data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd0_valid_q  <= 1'b0;
            rd0_mdata_q  <= '0;
            pipe_valid_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_mdata_q[i] <= '0;
                pipe_data_q[i]  <= '0;
            end
        end else begin
            rd0_valid_q  <= rd0_valid_d;
            rd0_mdata_q  <= rd0_mdata_d;
            pipe_valid_q <= pipe_valid_d;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_mdata_q[i] <= pipe_mdata_d[i];
                pipe_data_q[i]  <= pipe_data_d[i];
            end
        end
    end

    logic [PEND_W-1:0] pend_q, pend_d, retire_cnt;
    logic              flush_q, flush_d;
    logic              wr_accept, wr_drop, retire_two, retire_one;
    logic              rd_afull_q, rd_afull_d, wr_afull_q, wr_afull_d, err_q, err_d;
    logic [CNT_W-1:0]  rd_cnt_next;

    // Completions retire from registered state only: pairs always, a lone one only under flush.
    always_comb begin
        wr_accept   = wr_req_en && (pend_q != PEND_MAX);
        wr_drop     = wr_req_en && (pend_q == PEND_MAX);
        retire_two  = (pend_q >= PEND_TWO);
        retire_one  = (pend_q == PEND_ONE) && flush_q;
        retire_cnt  = retire_two ? PEND_TWO : (retire_one ? PEND_ONE : '0);
        pend_d      = pend_q + PEND_W'(wr_accept) - retire_cnt;
        flush_d     = (flush_q || (wr_req_en && wr_req_now)) && (pend_d != '0);
        rd_cnt_next = fifo_count + CNT_W'(rd_push_ok) - CNT_W'(rd_pop);
        rd_afull_d  = (rd_cnt_next >= RD_AFULL_TH);
        wr_afull_d  = (pend_d >= WR_AFULL_TH);
        err_d       = err_q || rd_drop || wr_drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            flush_q    <= 1'b0;
            rd_afull_q <= 1'b0;
            wr_afull_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            flush_q    <= flush_d;
            rd_afull_q <= rd_afull_d;
            wr_afull_q <= wr_afull_d;
            err_q      <= err_d;
        end
    end

    assign rd_req_almostfull = rd_afull_q;
    assign wr_req_almostfull = wr_afull_q;
    assign rd_rsp_valid      = pipe_valid_q[RD_LATENCY-1];
    assign rd_rsp_mdata      = pipe_mdata_q[RD_LATENCY-1];
    assign rd_rsp_data       = pipe_data_q[RD_LATENCY-1];
    assign wr_rsp_valid      = retire_two || retire_one;
    assign wr_rsp_rvalid     = retire_two;
    assign err_overflow      = err_q;

    logic unused_bits;
    assign unused_bits = &{1'b0, wr_req_mdata,
                           rd_req_addr[ADDR_LMT-1:MEM_DEPTH_LOG2],
                           wr_req_addr[ADDR_LMT+3:LANE_BITS+MEM_DEPTH_LOG2]};
endmodule

// File: tb/tb_ccie_mem_responder.sv
// Bench for ccie_mem_responder: read scoreboard against a line model, a vector
// table for write completions, and directed backpressure/hazard/reset sequences.
module tb_ccie_mem_responder;
  localparam int AW = 20;
  localparam int MW = 14;
  localparam int CW = 512;
  localparam int DL = 10;
  localparam int EW = MW + CW;

  logic          clk, rst;
  logic [AW-1:0] rd_req_addr;
  logic [MW-1:0] rd_req_mdata;
  logic          rd_req_en, rd_req_almostfull, rd_rsp_valid;
  logic [MW-1:0] rd_rsp_mdata;
  logic [CW-1:0] rd_rsp_data;
  logic [AW+3:0] wr_req_addr;
  logic [MW-1:0] wr_req_mdata;
  logic [CW-1:0] wr_req_data;
  logic          wr_req_en, wr_req_now, wr_req_direct;
  logic          wr_req_almostfull, wr_rsp_valid, wr_rsp_rvalid;
  logic          rd_throttle, err_overflow;

  ccie_mem_responder dut (
    .clk(clk), .rst(rst),
    .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata), .rd_req_en(rd_req_en),
    .rd_req_almostfull(rd_req_almostfull), .rd_rsp_valid(rd_rsp_valid),
    .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data),
    .wr_req_addr(wr_req_addr), .wr_req_mdata(wr_req_mdata), .wr_req_data(wr_req_data),
    .wr_req_en(wr_req_en), .wr_req_now(wr_req_now), .wr_req_direct(wr_req_direct),
    .wr_req_almostfull(wr_req_almostfull), .wr_rsp_valid(wr_rsp_valid),
    .wr_rsp_rvalid(wr_rsp_rvalid), .rd_throttle(rd_throttle), .err_overflow(err_overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [CW-1:0] model [1024];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct packed {
    logic en;
    logic now;
    logic exp_v;
    logic exp_r;
  } cpl_vec_t;
  cpl_vec_t cpl_tbl [15];

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] rand_line();
    logic [CW-1:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // driver tasks
  task automatic do_write(input logic [AW+3:0] addr, input logic [CW-1:0] data,
                          input logic direct, input logic now);
    wr_req_addr = addr;
    wr_req_data = data;
    wr_req_direct = direct;
    wr_req_now = now;
    wr_req_mdata = 14'($urandom);
    wr_req_en = 1'b1;
    if (direct) model[addr[DL+3:4]] = data;
    else model[addr[DL+3:4]][addr[3:0]*32 +: 32] = data[31:0];
    step();
    wr_req_en = 1'b0;
    wr_req_now = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [MW-1:0] tag, input logic accept);
    rd_req_addr = addr;
    rd_req_mdata = tag;
    rd_req_en = 1'b1;
    if (accept) exp_q.push_back({tag, model[addr[DL-1:0]]});
    step();
    rd_req_en = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) step();
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_afull"}, rd_req_almostfull, 1'b0);
    check({tag, "_rd_valid"}, rd_rsp_valid, 1'b0);
    check({tag, "_rd_mdata"}, rd_rsp_mdata, '0);
    check({tag, "_rd_data"}, rd_rsp_data, '0);
    check({tag, "_wr_afull"}, wr_req_almostfull, 1'b0);
    check({tag, "_wr_valid"}, wr_rsp_valid, 1'b0);
    check({tag, "_wr_rvalid"}, wr_rsp_rvalid, 1'b0);
    check({tag, "_err"}, err_overflow, 1'b0);
  endtask

  // scoreboard: every read response is compared against the oldest expectation
  always @(negedge clk) begin
    if (rd_rsp_valid) begin
      if (exp_q.size() == 0) check("rsp_unexpected", rd_rsp_valid, 1'b0);
      else begin
        mon_e = exp_q.pop_front();
        check("rsp_mdata", rd_rsp_mdata, mon_e[EW-1 -: MW]);
        check("rsp_data", rd_rsp_data, mon_e[CW-1:0]);
      end
    end
  end

  initial begin
    logic [CW-1:0] line5, hz_a;
    int lat, tb_cnt, stray;
    logic acc;

    cpl_tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    cpl_tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    cpl_tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    cpl_tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    cpl_tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    cpl_tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    cpl_tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    cpl_tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    cpl_tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    cpl_tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    cpl_tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1};
    cpl_tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0};
    cpl_tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0};
    cpl_tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1};
    cpl_tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    rd_req_addr = '0; rd_req_mdata = '0; rd_req_en = 1'b0;
    wr_req_addr = '0; wr_req_mdata = '0; wr_req_data = '0;
    wr_req_en = 1'b0; wr_req_now = 1'b0; wr_req_direct = 1'b0;
    rd_throttle = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check_idle_outputs("reset");

    // line readback and latency
    for (int i = 0; i < 16; i++) line5[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
    do_write(24'h50, line5, 1'b1, 1'b1);
    step();
    do_read(20'd5, 14'h2A, 1'b1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (rd_rsp_valid) begin
        lat = k;
        break;
      end
    end
    check("rd_latency", lat, 5);
    drain("readback_drain");

    // dword merge into lane 2 of line 5
    do_write(24'h52, {480'b0, 32'h0000_1234}, 1'b0, 1'b1);
    step();
    check("merge_model_lane2", model[5][95:64], 32'h0000_1234);
    do_read(20'd5, 14'h2B, 1'b1);
    drain("merge_drain");

    // write completions, one vector per cycle, outputs checked the cycle after
    for (int i = 0; i < 15; i++) begin
      wr_req_en = cpl_tbl[i].en;
      wr_req_now = cpl_tbl[i].now;
      wr_req_direct = 1'b1;
      wr_req_addr = 24'((100 + i) << 4);
      wr_req_data = rand_line();
      if (cpl_tbl[i].en) model[100 + i] = wr_req_data;
      step();
      check($sformatf("cpl_valid[%0d]", i), wr_rsp_valid, cpl_tbl[i].exp_v);
      check($sformatf("cpl_rvalid[%0d]", i), wr_rsp_rvalid, cpl_tbl[i].exp_r);
      check($sformatf("cpl_wr_afull[%0d]", i), wr_req_almostfull, 1'b0);
    end
    wr_req_en = 1'b0;
    wr_req_now = 1'b0;
    step();

    // backpressure with the throttle hook
    for (int i = 0; i < 8; i++) do_write(24'((16 + i) << 4), rand_line(), 1'b1, 1'b1);
    step();
    rd_throttle = 1'b1;
    tb_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      acc = (tb_cnt < 8);
      do_read(20'(16 + i), 14'(12'h100 + i), acc);
      if (acc) tb_cnt++;
      check($sformatf("bp_afull_push[%0d]", i), rd_req_almostfull, (tb_cnt >= 6));
      check($sformatf("bp_err[%0d]", i), err_overflow, (i == 8));
    end
    rd_throttle = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      tb_cnt--;
      check($sformatf("bp_afull_pop[%0d]", j), rd_req_almostfull, (tb_cnt >= 6));
    end
    drain("bp_drain");
    check("err_sticky", err_overflow, 1'b1);

    // hazard at the RAM read edge, then address wrap
    hz_a = rand_line();
    do_write(24'h70, hz_a, 1'b1, 1'b1);
    step();
    do_read(20'd7, 14'h07, 1'b1);
    do_write(24'h70, rand_line(), 1'b1, 1'b1);
    do_read(20'h407, 14'h08, 1'b1);
    drain("hazard_drain");

    // reset with reads in flight
    for (int i = 0; i < 4; i++) do_read(20'd5, 14'(12'h200 + i), 1'b1);
    rst = 1'b1;
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    check_idle_outputs("midrst");
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (rd_rsp_valid) stray++;
    end
    check("no_rsp_after_rst", stray, 0);
    do_read(20'd5, 14'h3F, 1'b1);
    drain("post_rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
